// File: rtl/fp_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_acc_pkg
// Description : Sizing helpers shared by the sfp multiply-accumulate blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_acc_pkg;

  // Extra integer bits needed so a sum of n products can never overflow.
  function automatic int acc_guard_bits(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Width of a counter running 0..n-1 (never narrower than one bit).
  function automatic int acc_cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_acc_core.sv
`default_nettype none
// ============================================================================
// Module      : sfp_acc_core
// Description : Frame accumulator: sample counter, guard-bit accumulator,
//               end-of-frame dump detection and synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_acc_core
  import fp_acc_pkg::*;
#(
  parameter int PW    = 16,
  parameter int N_ACC = 16,
  parameter int AW    = PW + acc_guard_bits(N_ACC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_p_vld,
  input  logic [PW-1:0] i_p,
  output logic [AW-1:0] o_sum,
  output logic          o_dump,
  output logic          o_cnt_nz
);

  localparam int              c_cw   = acc_cnt_width(N_ACC);
  localparam logic [c_cw-1:0] c_last = c_cw'(N_ACC - 1);

  generate
    if (N_ACC < 1) begin : g_bad_n_acc
      $error("sfp_acc_core: N_ACC must be at least 1");
    end
  endgenerate

  logic [c_cw-1:0]      r_cnt;
  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_p_ext;
  logic signed [AW-1:0] w_sum;
  logic                 w_last;

  assign w_p_ext  = AW'($signed(i_p));
  assign w_last   = (r_cnt == c_last);
  // A new frame starts from the product alone; acc holds stale data there.
  assign w_sum    = (r_cnt == '0) ? w_p_ext : (r_acc + w_p_ext);
  assign o_sum    = w_sum;
  assign o_dump   = i_p_vld & w_last & ~i_clear;
  assign o_cnt_nz = (r_cnt != '0);

  // Count products and accumulate; the last product of a frame only dumps.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_p_vld) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_sum;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfp_mult_full.sv
`default_nettype none
// ============================================================================
// Module      : sfp_mult_full
// Description : Full-precision signed fixed-point multiply (combinational).
//               Result has A_IW+B_IW integer and A_QW+B_QW fractional bits.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_mult_full #(
  parameter int A_IW = 2,
  parameter int A_QW = 6,
  parameter int B_IW = 2,
  parameter int B_QW = 6
) (
  input  logic [A_IW+A_QW-1:0]           i_a,
  input  logic [B_IW+B_QW-1:0]           i_b,
  output logic [A_IW+A_QW+B_IW+B_QW-1:0] o_p
);

  localparam int c_pw = A_IW + A_QW + B_IW + B_QW;

  // Operands are sign-extended to the product width so the multiply is exact.
  assign o_p = c_pw'($signed(i_a)) * c_pw'($signed(i_b));

endmodule
`default_nettype wire

// File: rtl/sfp_resize_ind.sv
`default_nettype none
// ============================================================================
// Module      : sfp_resize_ind
// Description : Signed fixed-point resize. Surplus fractional bits are
//               truncated (toward -inf); integer overflow wraps or clips.
//               o_clip flags any overflow in either mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_resize_ind #(
  parameter int IN_IW  = 6,
  parameter int IN_QW  = 12,
  parameter int OUT_IW = 4,
  parameter int OUT_QW = 8,
  parameter bit CLIP   = 1'b1
) (
  input  logic [IN_IW+IN_QW-1:0]   i_x,
  output logic [OUT_IW+OUT_QW-1:0] o_y,
  output logic                     o_clip
);

  localparam int c_mw = IN_IW + OUT_QW;   // width after fractional alignment
  localparam int c_ow = OUT_IW + OUT_QW;

  logic signed [c_mw-1:0] w_f;

  generate
    if (OUT_QW > IN_QW) begin : g_frac_pad
      assign w_f = {i_x, {(OUT_QW-IN_QW){1'b0}}};
    end else if (OUT_QW == IN_QW) begin : g_frac_same
      assign w_f = i_x;
    end else begin : g_frac_trunc
      assign w_f = c_mw'($signed(i_x) >>> (IN_QW - OUT_QW));
    end

    if (OUT_IW >= IN_IW) begin : g_int_ext
      assign o_y    = c_ow'(w_f);
      assign o_clip = 1'b0;
    end else begin : g_int_narrow
      logic w_ovf;
      // Overflow when the dropped integer bits are not copies of the new sign.
      assign w_ovf  = (w_f[c_mw-1:c_ow-1] != {(c_mw-c_ow+1){w_f[c_mw-1]}});
      assign o_clip = w_ovf;
      if (CLIP) begin : g_clip
        assign o_y = !w_ovf      ? w_f[c_ow-1:0] :
                     w_f[c_mw-1] ? {1'b1, {(c_ow-1){1'b0}}} :
                                   {1'b0, {(c_ow-1){1'b1}}};
      end else begin : g_wrap
        assign o_y = w_f[c_ow-1:0];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/sfp_mult_acc.sv
`default_nettype none
// ============================================================================
// Module      : sfp_mult_acc
// Description : Pipelined signed fixed-point multiply-accumulate. Sums N_ACC
//               valid products per frame and emits the resized sum with a
//               one-cycle valid pulse two cycles after the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
module sfp_mult_acc
  import fp_acc_pkg::*;
#(
  parameter int IN1_IW = 2,
  parameter int IN1_QW = 6,
  parameter int IN2_IW = 2,
  parameter int IN2_QW = 6,
  parameter int OUT_IW = 4,
  parameter int OUT_QW = 8,
  parameter int N_ACC  = 16,
  parameter bit CLIP   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN1_IW+IN1_QW-1:0] in1,
  input  logic [IN2_IW+IN2_QW-1:0] in2,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic [OUT_IW+OUT_QW-1:0] out,
  output logic                     out_valid,
  output logic                     clipping,
  output logic                     busy
);

  localparam int c_miw = IN1_IW + IN2_IW;
  localparam int c_mqw = IN1_QW + IN2_QW;
  localparam int c_pw  = c_miw + c_mqw;
  localparam int c_aw  = c_pw + acc_guard_bits(N_ACC);

  logic [c_pw-1:0]          w_prod;
  logic [c_pw-1:0]          r_p;
  logic                     r_p_vld;
  logic [c_aw-1:0]          w_sum;
  logic                     w_dump;
  logic                     w_cnt_nz;
  logic [OUT_IW+OUT_QW-1:0] w_res;
  logic                     w_res_clip;
  logic [OUT_IW+OUT_QW-1:0] r_out;
  logic                     r_out_valid;
  logic                     r_clipping;

  sfp_mult_full #(
    .A_IW(IN1_IW), .A_QW(IN1_QW), .B_IW(IN2_IW), .B_QW(IN2_QW)
  ) u_mult (
    .i_a(in1), .i_b(in2), .o_p(w_prod)
  );

  // Stage 1: capture the product; clear discards the sample and any in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_p_vld <= 1'b0;
    end else begin
      r_p_vld <= in_valid & ~clear;
      if (in_valid) r_p <= w_prod;
    end
  end

  sfp_acc_core #(
    .PW(c_pw), .N_ACC(N_ACC), .AW(c_aw)
  ) u_core (
    .clk(clk), .rst(rst), .i_clear(clear), .i_p_vld(r_p_vld), .i_p(r_p),
    .o_sum(w_sum), .o_dump(w_dump), .o_cnt_nz(w_cnt_nz)
  );

  sfp_resize_ind #(
    .IN_IW(c_miw + acc_guard_bits(N_ACC)), .IN_QW(c_mqw),
    .OUT_IW(OUT_IW), .OUT_QW(OUT_QW), .CLIP(CLIP)
  ) u_resize (
    .i_x(w_sum), .o_y(w_res), .o_clip(w_res_clip)
  );

  // Stage 2 output: register the resized frame sum only on a dump.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_clipping  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_dump;
      if (w_dump) begin
        r_out      <= w_res;
        r_clipping <= w_res_clip;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign clipping  = r_clipping;
  assign busy      = w_cnt_nz | r_p_vld;

endmodule
`default_nettype wire

// File: tb/tb_sfp_mult_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfp_mult_acc
// Description : Scoreboard bench for sfp_mult_acc. Three instances: N_ACC=4
//               clipping, N_ACC=4 wrapping, N_ACC=1 clipping. Formats are
//               in 2.6 x 2.6 -> out 4.8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfp_mult_acc;

  typedef struct {
    int         cyc;
    logic [11:0] val;
    logic       clp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [7:0]  in1 = '0, in2 = '0, in1b = '0, in2b = '0;
  logic        in_valid = 1'b0, vb = 1'b0;
  logic [11:0] out_c, out_w, out_1;
  logic        ov_c, ov_w, ov_1, clip_c, clip_w, clip_1, busy_c, busy_w, busy_1;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q_c[$], q_w[$], q_1[$];
  exp_t ec, ew, e1;

  always #5 clk = ~clk;

  // Free-running cycle counter used to time-stamp expected results.
  always @(posedge clk) cyc <= cyc + 1;

  sfp_mult_acc #(.IN1_IW(2), .IN1_QW(6), .IN2_IW(2), .IN2_QW(6), .OUT_IW(4), .OUT_QW(8),
                 .N_ACC(4), .CLIP(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_valid(in_valid), .clear(clear),
    .out(out_c), .out_valid(ov_c), .clipping(clip_c), .busy(busy_c));

  sfp_mult_acc #(.IN1_IW(2), .IN1_QW(6), .IN2_IW(2), .IN2_QW(6), .OUT_IW(4), .OUT_QW(8),
                 .N_ACC(4), .CLIP(1'b0)) dut_w (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .in_valid(in_valid), .clear(clear),
    .out(out_w), .out_valid(ov_w), .clipping(clip_w), .busy(busy_w));

  sfp_mult_acc #(.IN1_IW(2), .IN1_QW(6), .IN2_IW(2), .IN2_QW(6), .OUT_IW(4), .OUT_QW(8),
                 .N_ACC(1), .CLIP(1'b1)) dut_1 (
    .clk(clk), .rst(rst), .in1(in1b), .in2(in2b), .in_valid(vb), .clear(clear),
    .out(out_1), .out_valid(ov_1), .clipping(clip_1), .busy(busy_1));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic clr);
    @(posedge clk);
    #1;
    in_valid = v; in1 = a; in2 = b; clear = clr;
  endtask

  task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk);
    #1;
    vb = v; in1b = a; in2b = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  // Expected frame result for the two N_ACC=4 instances, due two cycles on.
  task automatic push_cw(input logic [11:0] vc, input logic cc, input logic [11:0] vw, input logic cw);
    exp_t e;
    e.cyc = cyc + 2; e.val = vc; e.clp = cc; q_c.push_back(e);
    e.val = vw; e.clp = cw; q_w.push_back(e);
  endtask

  task automatic push_1(input logic [11:0] v, input logic c);
    exp_t e;
    e.cyc = cyc + 2; e.val = v; e.clp = c; q_1.push_back(e);
  endtask

  // Monitor: each out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (ov_c) begin
      if (q_c.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL c_unexpected_valid: out_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        ec = q_c.pop_front();
        check("c_out", 32'(out_c), 32'(ec.val));
        check("c_clip", 32'(clip_c), 32'(ec.clp));
        check("c_cycle", cyc, ec.cyc);
      end
    end
    if (ov_w) begin
      if (q_w.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL w_unexpected_valid: out_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        ew = q_w.pop_front();
        check("w_out", 32'(out_w), 32'(ew.val));
        check("w_clip", 32'(clip_w), 32'(ew.clp));
        check("w_cycle", cyc, ew.cyc);
      end
    end
    if (ov_1) begin
      if (q_1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL n1_unexpected_valid: out_valid=1 at cycle %0d, expected 0", cyc);
      end else begin
        e1 = q_1.pop_front();
        check("n1_out", 32'(out_1), 32'(e1.val));
        check("n1_clip", 32'(clip_1), 32'(e1.clp));
        check("n1_cycle", cyc, e1.cyc);
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps[3] = '{1, 2, 3};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(out_c), 0);
    check("rst_out_valid", 32'(ov_c), 0);
    check("rst_clipping", 32'(clip_c), 0);
    check("rst_busy", 32'(busy_c), 0);
    check("rst_busy_n1", 32'(busy_1), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Nominal: 4 x 0.5*0.5 -> 1.0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20, 8'h20, 1'b0);
      if (i == 3) push_cw(12'h100, 1'b0, 12'h100, 1'b0);
    end
    idle(4);

    // Gapped input with busy tracking
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20, 8'h20, 1'b0);
      if (i == 3) push_cw(12'h100, 1'b0, 12'h100, 1'b0);
      @(negedge clk);
      check("gap_busy_sample", 32'(busy_c), (i == 0) ? 0 : 1);
      if (i < 3) begin
        for (int g = 0; g < gaps[i]; g++) begin
          drive(1'b0, 8'h00, 8'h00, 1'b0);
          @(negedge clk);
          check("gap_busy_idle", 32'(busy_c), 1);
        end
      end
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("gap_busy_dump", 32'(busy_c), 1);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    check("gap_busy_done", 32'(busy_c), 0);
    idle(3);

    // Overflow: 4 x -2.0*-2.0 = 16.0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h80, 8'h80, 1'b0);
      if (i == 3) push_cw(12'h7FF, 1'b1, 12'h000, 1'b1);
    end
    idle(4);

    // clear: partial frame and the coincident sample are dropped
    drive(1'b1, 8'h40, 8'h40, 1'b0);
    drive(1'b1, 8'h40, 8'h40, 1'b0);
    drive(1'b1, 8'h40, 8'h40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h10, 8'h40, 1'b0);
      if (i == 0) begin
        @(negedge clk);
        check("clear_busy", 32'(busy_c), 0);
      end
      if (i == 3) push_cw(12'h100, 1'b0, 12'h100, 1'b0);
    end
    idle(4);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h20, 8'h20, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out", 32'(out_c), 0);
    check("midrst_out_valid", 32'(ov_c), 0);
    check("midrst_busy", 32'(busy_c), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h20, 8'h20, 1'b0);
      if (i == 3) push_cw(12'h100, 1'b0, 12'h100, 1'b0);
    end
    idle(4);

    // N_ACC=1: -0.5*0.75 then 1.5*1.5 back to back
    drive1(1'b1, 8'hE0, 8'h30);
    push_1(12'hFA0, 1'b0);
    drive1(1'b1, 8'h60, 8'h60);
    push_1(12'h240, 1'b0);
    drive1(1'b0, 8'h00, 8'h00);
    repeat (5) @(posedge clk);

    // Every expected result must have been seen
    @(negedge clk);
    check("c_pending", q_c.size(), 0);
    check("w_pending", q_w.size(), 0);
    check("n1_pending", q_1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
